// File: rtl/uart_tuning_rx.sv
// ---------------------------------------------------------------------------
// uart_tuning_rx
//
// Receives 8N1 UART bytes (LSB first, idle high) and assembles 6-byte tuning
// frames of the form  0xA5, B0, B1, B2, B3, CHK  where CHK = B0^B1^B2^B3.
// A frame with a matching checksum updates the 32-bit frequency tuning word
// ftw = {B3,B2,B1,B0} that feeds the downstream OOK DDS phase accumulator.
//
// Ports
//   clk        in   1   single clock, all state changes on rising edge
//   rst_n      in   1   asynchronous active-low reset
//   rx         in   1   asynchronous UART serial line
//   ftw        out  32  current tuning word, held between valid frames
//   ftw_valid  out  1   one-cycle pulse in the cycle ftw takes a new value
//   frame_err  out  1   one-cycle pulse when a byte or frame is rejected
//
// Output handshake: ftw_valid is a pure strobe with no ready/back-pressure.
// The consumer must capture ftw in the cycle ftw_valid is high (ftw also
// stays stable afterwards until the next pulse). ftw_valid and frame_err are
// produced by the same parser decision and are never high together.
//
// Internal state is kept in two named enum registers (bit_state and
// parser_state) so checkers can bind to them directly.
// ---------------------------------------------------------------------------
module uart_tuning_rx #(
  parameter int CLKS_PER_BIT      = 104,
  parameter int IDLE_TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic [31:0] ftw,
  output logic        ftw_valid,
  output logic        frame_err
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int TIMEOUT  = IDLE_TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W     = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [TO_W-1:0]  TO_MAX    = TO_W'(TIMEOUT);
  localparam logic [7:0]       SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    BIT_IDLE,
    BIT_START,
    BIT_DATA,
    BIT_STOP,
    BIT_RECOVER
  } bit_state_t;

  typedef enum logic [1:0] {
    P_WAIT_SYNC,
    P_PAYLOAD,
    P_CHECK
  } parser_state_t;

  // -------------------------------------------------------------------------
  // Input synchronizer and start-edge detection
  // -------------------------------------------------------------------------
  logic       rx_meta;
  logic       rx_sync;
  logic [1:0] sync_fill;
  logic       line_high;
  logic       start_edge;

  // The synchronizer flops reset to 1, so right after reset rx_sync would
  // show a false 1->0 edge if the line is held low. sync_fill marks when the
  // synchronizer holds genuine line samples; line_high is the previous
  // genuine sample, so a start needs a real high followed by a real low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      sync_fill <= 2'b00;
      line_high <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_sync   <= rx_meta;
      sync_fill <= {sync_fill[0], 1'b1};
      line_high <= sync_fill[1] & rx_sync;
    end
  end

  assign start_edge = line_high & ~rx_sync;

  // -------------------------------------------------------------------------
  // Bit receiver FSM
  // -------------------------------------------------------------------------
  bit_state_t       bit_state, bit_state_n;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shift_reg, shift_n;
  logic             byte_stb, byte_stb_n;
  logic             stop_err, stop_err_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_state <= BIT_IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      byte_stb  <= 1'b0;
      stop_err  <= 1'b0;
    end else begin
      bit_state <= bit_state_n;
      bit_cnt   <= bit_cnt_n;
      bit_idx   <= bit_idx_n;
      shift_reg <= shift_n;
      byte_stb  <= byte_stb_n;
      stop_err  <= stop_err_n;
    end
  end

  always_comb begin
    bit_state_n = bit_state;
    bit_cnt_n   = bit_cnt;
    bit_idx_n   = bit_idx;
    shift_n     = shift_reg;
    byte_stb_n  = 1'b0;
    stop_err_n  = 1'b0;

    case (bit_state)
      BIT_IDLE: begin
        bit_cnt_n = '0;
        if (start_edge) begin
          bit_state_n = BIT_START;
        end
      end

      // Re-check the line half a bit in: a low level here is a genuine start
      // bit and the sample point is now centred in the bit cell.
      BIT_START: begin
        if (bit_cnt == HALF_LAST) begin
          bit_cnt_n = '0;
          if (!rx_sync) begin
            bit_state_n = BIT_DATA;
            bit_idx_n   = '0;
          end else begin
            bit_state_n = BIT_IDLE;
          end
        end else begin
          bit_cnt_n = bit_cnt + 1'b1;
        end
      end

      BIT_DATA: begin
        if (bit_cnt == BIT_LAST) begin
          bit_cnt_n = '0;
          shift_n   = {rx_sync, shift_reg[7:1]};
          if (bit_idx == 3'd7) begin
            bit_state_n = BIT_STOP;
          end else begin
            bit_idx_n = bit_idx + 1'b1;
          end
        end else begin
          bit_cnt_n = bit_cnt + 1'b1;
        end
      end

      BIT_STOP: begin
        if (bit_cnt == BIT_LAST) begin
          bit_cnt_n = '0;
          if (rx_sync) begin
            byte_stb_n  = 1'b1;
            bit_state_n = BIT_IDLE;
          end else begin
            stop_err_n  = 1'b1;
            bit_state_n = BIT_RECOVER;
          end
        end else begin
          bit_cnt_n = bit_cnt + 1'b1;
        end
      end

      // Framing error: wait for the line to return high before hunting for
      // the next start edge.
      BIT_RECOVER: begin
        bit_cnt_n = '0;
        if (rx_sync) begin
          bit_state_n = BIT_IDLE;
        end
      end

      default: begin
        bit_state_n = BIT_IDLE;
        bit_cnt_n   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Mid-frame idle timeout
  // -------------------------------------------------------------------------
  logic [TO_W-1:0] to_cnt;
  logic            timeout_hit;
  parser_state_t   parser_state, parser_state_n;

  // Only meaningful while a frame is partially received; a received byte
  // has priority over a coincident expiry.
  assign timeout_hit = (to_cnt == TO_MAX) && (parser_state != P_WAIT_SYNC) &&
                       (bit_state == BIT_IDLE) && !byte_stb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (byte_stb || (bit_state != BIT_IDLE) || timeout_hit) begin
      to_cnt <= '0;
    end else if (to_cnt != TO_MAX) begin
      // Saturate so a long idle in WAIT_SYNC never wraps the counter.
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Frame parser
  // -------------------------------------------------------------------------
  logic [1:0]  pay_idx, pay_idx_n;
  logic [31:0] shadow, shadow_n;
  logic [31:0] ftw_n;
  logic        ftw_valid_n;
  logic        frame_err_n;
  logic [7:0]  chk_calc;

  assign chk_calc = shadow[7:0] ^ shadow[15:8] ^ shadow[23:16] ^ shadow[31:24];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parser_state <= P_WAIT_SYNC;
      pay_idx      <= '0;
      shadow       <= '0;
      ftw          <= '0;
      ftw_valid    <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      parser_state <= parser_state_n;
      pay_idx      <= pay_idx_n;
      shadow       <= shadow_n;
      ftw          <= ftw_n;
      ftw_valid    <= ftw_valid_n;
      frame_err    <= frame_err_n;
    end
  end

  always_comb begin
    parser_state_n = parser_state;
    pay_idx_n      = pay_idx;
    shadow_n       = shadow;
    ftw_n          = ftw;
    ftw_valid_n    = 1'b0;
    frame_err_n    = 1'b0;

    if (stop_err) begin
      // A byte with a bad stop bit poisons whatever frame was in progress.
      frame_err_n    = 1'b1;
      parser_state_n = P_WAIT_SYNC;
    end else if (byte_stb) begin
      case (parser_state)
        P_WAIT_SYNC: begin
          if (shift_reg == SYNC_BYTE) begin
            parser_state_n = P_PAYLOAD;
            pay_idx_n      = '0;
          end
        end

        // Payload bytes arrive B0 first and fill the shadow register from the
        // low byte upward; 0xA5 is plain data in this state.
        P_PAYLOAD: begin
          shadow_n[{pay_idx, 3'b000} +: 8] = shift_reg;
          if (pay_idx == 2'd3) begin
            parser_state_n = P_CHECK;
          end else begin
            pay_idx_n = pay_idx + 1'b1;
          end
        end

        P_CHECK: begin
          if (shift_reg == chk_calc) begin
            ftw_n       = shadow;
            ftw_valid_n = 1'b1;
          end else begin
            frame_err_n = 1'b1;
          end
          parser_state_n = P_WAIT_SYNC;
        end

        default: begin
          parser_state_n = P_WAIT_SYNC;
        end
      endcase
    end else if (timeout_hit) begin
      frame_err_n    = 1'b1;
      parser_state_n = P_WAIT_SYNC;
    end
  end

endmodule

// File: tb/tb_uart_tuning_rx.sv
module tb_uart_tuning_rx;

  localparam int CPB   = 16;
  localparam int TO_BT = 20;

  logic        clk;
  logic        rst_n;
  logic        rx;
  logic [31:0] ftw;
  logic        ftw_valid;
  logic        frame_err;

  int checks = 0;
  int errors = 0;

  // Scoreboard: tuning words the bench expects to be published, in order.
  logic [31:0] exp_q[$];
  logic [31:0] cur_ftw;   // model of the value ftw must hold
  int          n_valid = 0;
  int          n_err   = 0;
  int          cyc     = 0;
  int          last_err_cyc = 0;

  uart_tuning_rx #(
    .CLKS_PER_BIT     (CPB),
    .IDLE_TIMEOUT_BITS(TO_BT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .ftw      (ftw),
    .ftw_valid(ftw_valid),
    .frame_err(frame_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- checker helper ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- output monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (ftw_valid || frame_err) begin
        check("valid_err_exclusive", {31'd0, ftw_valid && frame_err}, 32'd0);
      end
      if (ftw_valid) begin
        n_valid++;
        check("ftw_valid_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          check("ftw_on_valid", ftw, exp_q.pop_front());
        end
      end
      if (frame_err) begin
        n_err++;
        last_err_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks (all called aligned to a negedge) ----------------
  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
    send_byte(b0, 1'b1); idle($urandom_range(0, 12));
    send_byte(b1, 1'b1); idle($urandom_range(0, 12));
    send_byte(b2, 1'b1); idle($urandom_range(0, 12));
    send_byte(b3, 1'b1); idle($urandom_range(0, 12));
    send_byte(b4, 1'b1); idle($urandom_range(0, 12));
    send_byte(b5, 1'b1);
  endtask

  // Reference model: a frame is accepted when CHK equals the XOR of the four
  // payload bytes; the word is B3..B0 with B0 least significant.
  task automatic model_frame(input logic [31:0] word, input logic [7:0] chk, inout int exp_err);
    logic [7:0] want;
    want = word[7:0] ^ word[15:8] ^ word[23:16] ^ word[31:24];
    if (chk == want) begin
      exp_q.push_back(word);
      cur_ftw = word;
    end else begin
      exp_err++;
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int v0, e0, exp_err, t_end, dt;
    logic [31:0] w;
    logic [7:0]  chk, junk;

    rst_n   = 1'b0;
    rx      = 1'b1;
    cur_ftw = 32'd0;
    repeat (10) @(negedge clk);
    check("reset_ftw", ftw, 32'd0);
    check("reset_ftw_valid", {31'd0, ftw_valid}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    rst_n = 1'b1;
    idle(40);

    // Good frame
    v0 = n_valid; e0 = n_err; exp_err = 0;
    model_frame(32'h12345678, 8'h08, exp_err);
    send_frame(8'hA5, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08);
    idle(40);
    check("s1_ftw", ftw, 32'h12345678);
    check("s1_valid_count", n_valid - v0, 1);
    check("s1_err_count", n_err - e0, exp_err);

    // Bad checksum
    v0 = n_valid; e0 = n_err; exp_err = 0;
    model_frame(32'h12345678, 8'h09, exp_err);
    send_frame(8'hA5, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09);
    idle(40);
    check("s2_err_count", n_err - e0, 1);
    check("s2_valid_count", n_valid - v0, 0);
    check("s2_ftw", ftw, 32'h12345678);

    // Leading junk ignored
    v0 = n_valid; e0 = n_err; exp_err = 0;
    send_byte(8'h00, 1'b1); idle(5);
    send_byte(8'h33, 1'b1); idle(5);
    model_frame(32'h80000001, 8'h81, exp_err);
    send_frame(8'hA5, 8'h01, 8'h00, 8'h00, 8'h80, 8'h81);
    idle(40);
    check("s3_ftw", ftw, 32'h80000001);
    check("s3_err_count", n_err - e0, 0);
    check("s3_valid_count", n_valid - v0, 1);

    // Short low glitch is not a start bit
    v0 = n_valid; e0 = n_err;
    rx = 1'b0; repeat (4) @(negedge clk);
    idle(200);
    check("glitch_err_count", n_err - e0, 0);
    check("glitch_valid_count", n_valid - v0, 0);
    check("glitch_ftw", ftw, cur_ftw);
    exp_err = 0;
    w   = $urandom;
    chk = w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
    model_frame(w, chk, exp_err);
    send_frame(8'hA5, w[7:0], w[15:8], w[23:16], w[31:24], chk);
    idle(40);
    check("glitch_next_ftw", ftw, w);

    // Stop bit forced low on B1, then a clean frame
    v0 = n_valid; e0 = n_err;
    send_byte(8'hA5, 1'b1); idle(3);
    send_byte(8'h78, 1'b1); idle(3);
    send_byte(8'h56, 1'b0);
    idle(2 * CPB);
    check("stop_err_count", n_err - e0, 1);
    check("stop_err_ftw", ftw, w);
    exp_err = 0;
    model_frame(32'h12345678, 8'h08, exp_err);
    send_frame(8'hA5, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08);
    idle(40);
    check("stop_recover_ftw", ftw, 32'h12345678);
    check("stop_recover_valid", n_valid - v0, 1);
    check("stop_recover_err", n_err - e0, 1);

    // Mid-frame idle timeout
    v0 = n_valid; e0 = n_err;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    t_end = cyc;
    idle(400);
    dt = last_err_cyc - t_end;
    check("timeout_err_count", n_err - e0, 1);
    check("timeout_window", {31'd0, (dt >= 312) && (dt <= 322)}, 32'd1);
    check("timeout_ftw", ftw, 32'h12345678);
    check("timeout_valid_count", n_valid - v0, 0);

    // Reset in the middle of B0, line held low across release
    send_byte(8'hA5, 1'b1);
    rx = 1'b0; repeat (CPB) @(negedge clk);
    rx = 1'b1; repeat (3 * CPB) @(negedge clk);
    rx = 1'b0;
    rst_n = 1'b0;
    cur_ftw = 32'd0;
    repeat (5) @(negedge clk);
    check("midreset_ftw", ftw, 32'd0);
    rst_n = 1'b1;
    v0 = n_valid; e0 = n_err;
    repeat (40) @(negedge clk);
    idle(40);
    check("post_reset_err", n_err - e0, 0);
    check("post_reset_valid", n_valid - v0, 0);
    check("post_reset_ftw", ftw, 32'd0);
    exp_err = 0;
    model_frame(32'hCAFE0123, 8'hCA ^ 8'hFE ^ 8'h01 ^ 8'h23, exp_err);
    send_frame(8'hA5, 8'h23, 8'h01, 8'hFE, 8'hCA, 8'hCA ^ 8'hFE ^ 8'h01 ^ 8'h23);
    idle(40);
    check("post_reset_frame_ftw", ftw, 32'hCAFE0123);

    // Randomized frames with leading junk and occasional bad checksums
    for (int f = 0; f < 8; f++) begin
      v0 = n_valid; e0 = n_err; exp_err = 0;
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        junk = 8'($urandom_range(0, 254));
        if (junk >= 8'hA5) junk = junk + 8'd1;
        send_byte(junk, 1'b1);
        idle($urandom_range(0, 10));
      end
      w   = $urandom;
      chk = w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
      if ($urandom_range(0, 3) == 0) chk = chk ^ 8'($urandom_range(1, 255));
      model_frame(w, chk, exp_err);
      send_frame(8'hA5, w[7:0], w[15:8], w[23:16], w[31:24], chk);
      idle(40);
      check("rand_ftw", ftw, cur_ftw);
      check("rand_err_count", n_err - e0, exp_err);
      check("rand_valid_count", n_valid - v0, 1 - exp_err);
    end

    check("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tuning_rx.md
UART_TUNING_RX -- requirements
Module: uart_tuning_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 104: clock cycles per UART bit; legal values are 8 and above.
REQ-002 Parameter IDLE_TIMEOUT_BITS, default 20: bit periods of idle line mid-frame before the parser aborts.
REQ-003 clk  input  1: single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1: reset, asynchronous assert, active-low.
REQ-005 rx  input  1: asynchronous UART serial line, 8N1, LSB first, idle high.
REQ-006 ftw  output  32: frequency tuning word driven to the downstream OOK DDS phase accumulator.
REQ-007 ftw_valid  output  1: one-cycle pulse in the cycle ftw takes a new value.
REQ-008 frame_err  output  1: one-cycle pulse when a byte or frame is rejected.

Function
REQ-009 rx SHALL pass through a 2-flop synchronizer; all detection uses the synchronized value.
REQ-010 Bit receiver FSM states SHALL be IDLE, START, DATA, STOP, RECOVER.
REQ-011 IDLE->START on synchronized rx 1->0 transition; a line already low is not a start.
REQ-012 START: after CLKS_PER_BIT/2 cycles (integer division), rx=0 -> DATA with bit counter cleared; rx=1 -> IDLE, no error (glitch).
REQ-013 DATA: sample rx every CLKS_PER_BIT cycles, 8 samples, shifted in LSB first; then -> STOP.
REQ-014 STOP: sample after CLKS_PER_BIT cycles; rx=1 -> internal byte strobe (1 cycle) and -> IDLE.
REQ-015 STOP with rx=0 -> discard byte, pulse frame_err, parser -> WAIT_SYNC, FSM -> RECOVER; RECOVER -> IDLE on first rx=1.
REQ-016 Frame format SHALL be 6 bytes: 0xA5, B0, B1, B2, B3, CHK; ftw = {B3,B2,B1,B0}; CHK = B0^B1^B2^B3.
REQ-017 Parser states SHALL be WAIT_SYNC, PAYLOAD (index 0..3), CHECK.
REQ-018 WAIT_SYNC: byte 0xA5 -> PAYLOAD index 0; any other byte ignored silently.
REQ-019 PAYLOAD: bytes load a 32-bit shadow register, not ftw; 0xA5 is ordinary data here; after index 3 -> CHECK.
REQ-020 CHECK with CHK match: ftw <= shadow and ftw_valid=1 in the cycle after the checksum byte strobe; -> WAIT_SYNC.
REQ-021 CHECK with mismatch: frame_err pulse, ftw unchanged, -> WAIT_SYNC.
REQ-022 Timeout counter SHALL clear on every byte strobe and whenever the bit FSM is not IDLE, and increment otherwise.
REQ-023 When the counter reaches IDLE_TIMEOUT_BITS*CLKS_PER_BIT with parser not in WAIT_SYNC: frame_err pulse, parser -> WAIT_SYNC, counter clears.
REQ-024 ftw SHALL hold its value between valid frames; ftw_valid and frame_err SHALL never be high in the same cycle.
REQ-025 Counters SHALL be sized to ceil(log2(max count+1)); no wrap inside a bit period or the timeout window.

Reset
REQ-026 While rst_n=0: ftw=0, ftw_valid=0, frame_err=0, synchronizer flops=1, bit FSM=IDLE, parser=WAIT_SYNC, counters and shadow=0.
REQ-027 Reset mid-frame SHALL discard the partial frame; after release a new 0xA5 is required, and rx low at release is not a start bit.

Verification (CLKS_PER_BIT=16, IDLE_TIMEOUT_BITS=20)
REQ-028 Send A5 78 56 34 12 08 -> ftw=0x12345678, ftw_valid high exactly 1 cycle, frame_err never high.
REQ-029 Send A5 78 56 34 12 09 after scenario 1 -> one frame_err pulse, ftw stays 0x12345678, no ftw_valid.
REQ-030 Send 00 33 then A5 01 00 00 80 81 -> leading bytes ignored, no error, ftw=0x80000001.
REQ-031 4-cycle low glitch on rx, then idle -> no byte strobe, no frame_err, ftw unchanged; next valid frame accepted.
REQ-032 Stop bit forced 0 on B1 -> frame_err 1 pulse; following clean frame A5 78 56 34 12 08 -> ftw=0x12345678.
REQ-033 Send A5 11 22, idle 320 cycles -> frame_err at cycle 320; repeat, assert rst_n mid-B0 -> ftw=0; subsequent valid frame accepted.
